// File: rtl/gray_code_pipe.sv
// Registered binary<->Gray stream converter with a 2-entry skid buffer.
// Define GRAY_CNT_EN to compile in the self-sequencing counter source (cnt_go/cnt_busy).
module gray_code_pipe #(
    parameter int WIDTH    = 4,
    parameter int MAX_CODE = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_err
`ifdef GRAY_CNT_EN
    ,
    input  logic             cnt_go,
    output logic             cnt_busy
`endif
);

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             src_mode;
    logic             accept;
    logic             out_xfer;

    logic [WIDTH-1:0] enc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] bin_val;
    logic [WIDTH-1:0] res_data;
    logic             res_err;

    logic             or_valid_q, or_valid_d;
    logic [WIDTH-1:0] or_data_q,  or_data_d;
    logic             or_mode_q,  or_mode_d;
    logic             or_err_q,   or_err_d;
    logic             sk_valid_q, sk_valid_d;
    logic [WIDTH-1:0] sk_data_q,  sk_data_d;
    logic             sk_mode_q,  sk_mode_d;
    logic             sk_err_q,   sk_err_d;
    logic             in_ready_q, in_ready_d;

    // Encode is a neighbour XOR; decode is a running XOR from the MSB down.
    assign enc[WIDTH-1] = src_data[WIDTH-1];
    assign dec[WIDTH-1] = src_data[WIDTH-1];
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_conv
            assign enc[gi] = src_data[gi+1] ^ src_data[gi];
            assign dec[gi] = dec[gi+1] ^ src_data[gi];
        end
    endgenerate

    assign bin_val  = src_mode ? dec : src_data;
    assign res_data = src_mode ? dec : enc;
    assign res_err  = (32'(bin_val) > 32'(MAX_CODE));

    assign out_xfer = or_valid_q & out_ready;

`ifdef GRAY_CNT_EN
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;

    assign src_valid = (state_q == RUN) ? 1'b1 : in_valid;
    assign src_data  = (state_q == RUN) ? cnt_q : in_data;
    assign src_mode  = (state_q == RUN) ? 1'b0 : in_mode;
    assign accept    = (state_q == RUN) ? ~sk_valid_q : (in_valid & in_ready_q);
    assign cnt_busy  = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cnt_go && !or_valid_q && !sk_valid_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (cnt_q == WIDTH'(MAX_CODE)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_d = ~sk_valid_d & (state_d == IDLE);
`else
    assign src_valid  = in_valid;
    assign src_data   = in_data;
    assign src_mode   = in_mode;
    assign accept     = in_valid & in_ready_q;
    assign in_ready_d = ~sk_valid_d;
`endif

    // An accepted word can only land in SK when OR is full and not draining,
    // and in_ready is low whenever SK is full, so no third slot is ever needed.
    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        or_mode_d  = or_mode_q;
        or_err_d   = or_err_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_mode_d  = sk_mode_q;
        sk_err_d   = sk_err_q;

        if (out_xfer) begin
            if (sk_valid_q) begin
                or_data_d  = sk_data_q;
                or_mode_d  = sk_mode_q;
                or_err_d   = sk_err_q;
                sk_valid_d = 1'b0;
            end else begin
                or_valid_d = 1'b0;
            end
        end

        if (accept && src_valid) begin
            if (!or_valid_q || out_xfer) begin
                or_valid_d = 1'b1;
                or_data_d  = res_data;
                or_mode_d  = src_mode;
                or_err_d   = res_err;
            end else begin
                sk_valid_d = 1'b1;
                sk_data_d  = res_data;
                sk_mode_d  = src_mode;
                sk_err_d   = res_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_mode_q  <= 1'b0;
            or_err_q   <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            sk_mode_q  <= 1'b0;
            sk_err_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_mode_q  <= or_mode_d;
            or_err_q   <= or_err_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            sk_mode_q  <= sk_mode_d;
            sk_err_q   <= sk_err_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = or_valid_q;
    assign out_data  = or_data_q;
    assign out_mode  = or_mode_q;
    assign out_err   = or_err_q;

endmodule

// File: tb/tb_gray_code_pipe.sv
// Scoreboard bench for gray_code_pipe: directed vectors, stall/skid, reset flush,
// random traffic, and the counter source when GRAY_CNT_EN is defined.
module tb_gray_code_pipe;

    localparam int W = 4;
    localparam int MAXC = 9;

    typedef struct packed {
        logic [W-1:0] d;
        logic         m;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_mode;
    logic         out_err;
    logic         cnt_go = 1'b0;
    logic         cnt_busy;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    gray_code_pipe #(.WIDTH(W), .MAX_CODE(MAXC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_err   (out_err)
`ifdef GRAY_CNT_EN
        ,
        .cnt_go    (cnt_go),
        .cnt_busy  (cnt_busy)
`endif
    );

`ifndef GRAY_CNT_EN
    assign cnt_busy = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference: Gray code of n is n xor n/2; decoding searches for the preimage.
    function automatic int to_gray(int b);
        return (b ^ (b / 2)) % (1 << W);
    endfunction

    function automatic int from_gray(int g);
        for (int b = 0; b < (1 << W); b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    function automatic exp_t model(int data, bit mode);
        exp_t r;
        int   b;
        b   = mode ? from_gray(data) : data;
        r.d = W'(mode ? b : to_gray(data));
        r.m = mode;
        r.e = (b > MAXC);
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) sb.push_back(model(int'(in_data), in_mode));
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got data=%b mode=%0d err=%0d expected nothing",
                         out_data, out_mode, out_err);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.d || out_mode !== e.m || out_err !== e.e) begin
                    bad++;
                    $display("FAIL out_word: got data=%b mode=%0d err=%0d expected data=%b mode=%0d err=%0d",
                             out_data, out_mode, out_err, e.d, e.m, e.e);
                end else begin
                    $display("tx data=%b mode=%0d err=%0d", out_data, out_mode, out_err);
                end
            end
        end
    end

    task automatic drain(string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, int'(out_valid), 0);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    int dir_data[6] = '{4'b0101, 4'b1001, 4'b0111, 4'b1101, 4'b1100, 4'b1010};
    bit dir_mode[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int dir_res[6]  = '{4'b0111, 4'b1101, 4'b0101, 4'b1001, 4'b1010, 4'b1100};
    bit dir_err[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int  k;
        int  c;
        bit  acc;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_mode", int'(out_mode), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_cnt_busy", int'(cnt_busy), 0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Directed vectors, one per cycle with alternating directions
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = W'(dir_data[i]);
            in_mode  = dir_mode[i];
            @(posedge clk); #1;
            chk("dir_valid", int'(out_valid), 1);
            chk("dir_data", int'(out_data), dir_res[i]);
            chk("dir_mode", int'(out_mode), int'(dir_mode[i]));
            chk("dir_err", int'(out_err), int'(dir_err[i]));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Stream 0..9 encoded, sink stalled for cycles 2..6
        k = 0;
        c = 0;
        while (k < 10 && c < 100) begin
            out_ready = !(c >= 2 && c < 7);
            in_valid  = 1'b1;
            in_data   = W'(k);
            in_mode   = 1'b0;
            if (c == 2) chk("stall_ready_c2", int'(in_ready), 1);
            if (c == 3) chk("stall_ready_c3", int'(in_ready), 0);
            if (c >= 3 && c < 7) begin
                chk("stall_hold_valid", int'(out_valid), 1);
                chk("stall_hold_data", int'(out_data), to_gray(1));
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            c++;
        end
        chk("stall_all_sent", k, 10);
        drain("stall");

        // Fill both entries, then reset mid-cycle
        out_ready = 1'b0;
        k = 0;
        c = 0;
        while (k < 2 && c < 20) begin
            in_valid = 1'b1;
            in_data  = W'(k + 5);
            in_mode  = 1'b1;
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            c++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_valid", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'b0011;
        in_mode   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_data", int'(out_data), 4'b0010);
        drain("post_rst");

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = W'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        drain("random");

`ifdef GRAY_CNT_EN
        // Self-sequence: expected words are the encoded values 0..MAX_CODE
        cnt_go = 1'b1;
        for (int i = 0; i <= MAXC; i++) sb.push_back(model(i, 1'b0));
        @(posedge clk); #1;
        cnt_go = 1'b0;
        chk("cnt_busy_set", int'(cnt_busy), 1);
        chk("cnt_in_ready", int'(in_ready), 0);
        c = 0;
        while (cnt_busy && c < 200) begin
            out_ready = ($urandom % 3) != 0;
            in_valid  = 1'b1;
            in_data   = W'($urandom);
            @(posedge clk); #1;
            c++;
        end
        chk("cnt_busy_fell", int'(cnt_busy), 0);
        drain("cnt");
        chk("cnt_in_ready_back", int'(in_ready), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gray_code_pipe.md
# gray_code_pipe

Parametrised, registered binary↔Gray code converter with a valid/ready stream interface. It is the successor to the fixed 4-bit combinational BCD-to-Gray block, and adds:
- selectable conversion direction per transfer
- arbitrary width
- out-of-range code flagging
- a 2-entry skid buffer for full throughput under backpressure

It sits between a code source (counter, encoder, sampler) and any stream consumer.

## Interface
- WIDTH, 4, data width in bits (≥2)
- MAX_CODE, 9, largest legal binary value; larger values are flagged (9 = BCD digit)

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  source has a word
- in_ready  output  1  block can accept; registered
- in_data  input  WIDTH  word to convert
- in_mode  input  1  0 = binary→Gray, 1 = Gray→binary
- out_valid  output  1  out_* hold a result
- out_ready  input  1  sink accepts
- out_data  output  WIDTH  converted word
- out_mode  output  1  in_mode of this result
- out_err  output  1  binary value of this result > MAX_CODE
- cnt_go  input  1  start self-sequence (only with GRAY_CNT_EN)
- cnt_busy  output  1  self-sequence running (only with GRAY_CNT_EN)

## Operation
- Encode: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] ^ b[i].
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. This is a prefix-XOR from the MSB.
- out_err is computed on the binary side of the transfer:
  - encode: in_data > MAX_CODE
  - decode: decoded value > MAX_CODE
- Flagged words are still converted and delivered; nothing is dropped.
- Storage is an output register (OR) plus a skid register (SK). Each entry holds {data, mode, err}.
- Accept: in_valid & in_ready.
- Output transfer: out_valid & out_ready.
- in_ready = ~SK.valid.
- On accept:
  - if OR is empty or transferring this cycle, the result loads into OR;
  - otherwise it loads into SK.
- On output transfer with SK full: SK moves to OR, and SK empties.
- Ordering is strict FIFO. No result is lost or duplicated.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_mode=0, out_err=0, cnt_busy=0. Both entries are empty.
- Reset asserted mid-stream discards both entries immediately.

## Timing
- Latency: 1 cycle. A word accepted at edge N is on out_data after edge N with out_valid=1.
- Throughput: 1 word/cycle while out_ready=1.
- While out_valid=1 and out_ready=0, out_data, out_mode and out_err are stable.
- in_ready falls 1 cycle after the skid register fills. At most one extra word is absorbed after out_ready drops.
- Simultaneous accept and output transfer with SK empty: OR reloads with the new word, and out_valid stays 1.
- Simultaneous accept and output transfer with SK full: cannot occur, because in_ready=0.
- in_mode may change on every accepted word. Direction is latched per word.

## Configuration
GRAY_CNT_EN compiles in a self-test source and the ports cnt_go and cnt_busy.

With GRAY_CNT_EN defined:
- State machine has two states, IDLE and RUN.
- IDLE→RUN on cnt_go=1 when both entries are empty.
- In RUN:
  - in_ready=0 and in_* are ignored.
  - A binary counter drives the encode path with values 0,1,…,MAX_CODE, one word per free slot, all with mode 0.
- After MAX_CODE is accepted, RUN→IDLE and the counter clears.
- cnt_busy=1 exactly in RUN.
- cnt_go in RUN is ignored.
- Reset returns the machine to IDLE.

Without GRAY_CNT_EN:
- The ports are absent.
- The block is the pure stream converter described above.

## Test plan
- WIDTH=4, encode in_data=0101, out_ready=1 → next cycle out_data=0111, out_err=0. Encode 1001 → 1101, err=0.
- Decode 0111 → 0101. Decode 1101 → 1001. Back-to-back alternating modes at 1 word/cycle → correct per-word out_mode.
- Encode 1100 (12 > 9) → out_data=1010, out_err=1. Decode 1010 → 1100, out_err=1.
- Stream 0..9 with out_ready held low from cycle 2 for 5 cycles:
  - in_ready drops after exactly 2 words are stored;
  - out_data stays stable while stalled;
  - after release all 10 words arrive in order without loss.
- Assert rst mid-stream with both entries full → out_valid=0 and in_ready=1 immediately. The first word after release is the first one accepted.
- GRAY_CNT_EN, pulse cnt_go → out_data sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101. cnt_busy then falls, and in_ready returns to 1.
